// File: rtl/tl_pkg.sv
// Phase codes and lamp patterns shared by the intersection scheduler.
// Lamp order is {A_G,A_Y,A_R,B_G,B_Y,B_R}.
package tl_pkg;

  typedef enum logic [3:0] {
    S_AG    = 4'd0,
    S_AY    = 4'd1,
    S_CLR_A = 4'd2,
    S_BG    = 4'd3,
    S_BY    = 4'd4,
    S_CLR_B = 4'd5,
    S_WALK  = 4'd6,
    S_EMRG  = 4'd7,
    S_FLASH = 4'd8
  } state_t;

  localparam logic [5:0] TL_AG       = 6'b100001;
  localparam logic [5:0] TL_AY       = 6'b010001;
  localparam logic [5:0] TL_ALLRED   = 6'b001001;
  localparam logic [5:0] TL_BG       = 6'b001100;
  localparam logic [5:0] TL_BY       = 6'b001010;
  localparam logic [5:0] TL_FLASH_ON = 6'b010010;
  localparam logic [5:0] TL_OFF      = 6'b000000;

  // Unknown codes fall back to all-red so opposing roads can never both be open.
  function automatic logic [5:0] tl_lamps(input state_t s, input logic flash_ph);
    logic [5:0] lamps;
    lamps = TL_ALLRED;
    case (s)
      S_AG:    lamps = TL_AG;
      S_AY:    lamps = TL_AY;
      S_BG:    lamps = TL_BG;
      S_BY:    lamps = TL_BY;
      S_FLASH: lamps = flash_ph ? TL_FLASH_ON : TL_OFF;
      default: lamps = TL_ALLRED;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter timing one phase; load wins over tick.
// expire flags a tick arriving while the count is already zero.
module tl_phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          load,
  input  logic [TW-1:0] val,
  input  logic          tick,
  output logic          expire
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (load) begin
      r_count <= val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign expire = tick & (r_count == '0);

endmodule

// File: rtl/tl_phase_scheduler.sv
// Two-road phase sequencer with pedestrian latch, emergency all-red and flash mode.
// State, lamps and walk are registered together; the timer reloads on every state change.
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          enable,
  input  logic          emerg,
  input  logic          ped_req,
  input  logic [TW-1:0] t_green_a,
  input  logic [TW-1:0] t_green_b,
  input  logic [TW-1:0] t_yellow,
  input  logic [TW-1:0] t_allred,
  input  logic [TW-1:0] t_walk,
  output logic [5:0]    TL,
  output logic          walk,
  output logic          ped_ack,
  output logic [3:0]    phase
);

  state_t        r_state;
  logic          r_ped_pend;
  logic          r_flash_ph;
  logic [5:0]    r_tl;
  logic          r_walk;
  logic          r_ped_ack;

  state_t        w_next;
  logic          w_expire;
  logic          w_load;
  logic [TW-1:0] w_val;
  logic          w_walk_entry;
  logic          w_flash_nxt;

  always_comb begin
    w_next = r_state;
    if (emerg) begin
      w_next = S_EMRG;
    end else if (!enable) begin
      w_next = S_FLASH;
    end else begin
      case (r_state)
        S_AG:    if (w_expire) w_next = S_AY;
        S_AY:    if (w_expire) w_next = S_CLR_A;
        S_CLR_A: if (w_expire) w_next = S_BG;
        S_BG:    if (w_expire) w_next = S_BY;
        S_BY:    if (w_expire) w_next = S_CLR_B;
        S_CLR_B: if (w_expire) w_next = r_ped_pend ? S_WALK : S_AG;
        S_WALK:  if (w_expire) w_next = S_AG;
        default: w_next = S_CLR_B;
      endcase
    end
  end

  // Durations are sampled only here, so edits mid-phase apply from the next phase.
  always_comb begin
    w_val = t_allred;
    if (reset) begin
      case (w_next)
        S_AG:          w_val = t_green_a;
        S_BG:          w_val = t_green_b;
        S_AY, S_BY:    w_val = t_yellow;
        S_WALK:        w_val = t_walk;
        default:       w_val = t_allred;
      endcase
    end
  end

  assign w_load       = !reset || (w_next != r_state);
  assign w_walk_entry = (w_next == S_WALK) && (r_state != S_WALK);
  assign w_flash_nxt  = ((r_state == S_FLASH) && (w_next == S_FLASH)) ? (r_flash_ph ^ tick) : 1'b0;

  tl_phase_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .load   (w_load),
    .val    (w_val),
    .tick   (tick),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_CLR_B;
      r_tl       <= TL_ALLRED;
      r_walk     <= 1'b0;
      r_ped_ack  <= 1'b0;
      r_ped_pend <= 1'b0;
      r_flash_ph <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_flash_ph <= w_flash_nxt;
      r_tl       <= tl_lamps(w_next, w_flash_nxt);
      r_walk     <= (w_next == S_WALK);
      r_ped_ack  <= w_walk_entry;
      r_ped_pend <= ped_req | (r_ped_pend & ~w_walk_entry);
    end
  end

  assign TL      = r_tl;
  assign walk    = r_walk;
  assign ped_ack = r_ped_ack;
  assign phase   = r_state;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed scenarios then random traffic, compared cycle by cycle with a tick-counting model.
module tb_tl_phase_scheduler;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset, tick, enable, emerg, ped_req;
  logic [TW-1:0] t_green_a, t_green_b, t_yellow, t_allred, t_walk;
  logic [5:0]    TL;
  logic          walk, ped_ack;
  logic [3:0]    phase;

  always #5 clk = ~clk;

  tl_phase_scheduler #(.TW(TW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .emerg(emerg),
    .ped_req(ped_req), .t_green_a(t_green_a), .t_green_b(t_green_b),
    .t_yellow(t_yellow), .t_allred(t_allred), .t_walk(t_walk),
    .TL(TL), .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Model: the normal cycle is a ring of six phases, each lasting (duration+1) ticks.
  localparam int M_AG = 0, M_AY = 1, M_CLRA = 2, M_BG = 3, M_BY = 4, M_CLRB = 5;
  localparam int M_WALK = 6, M_EMRG = 7, M_FLASH = 8;

  int m_ph   = M_CLRB;
  int m_rem  = 1;
  bit m_pend = 0;
  bit m_fph  = 0;
  bit m_ack  = 0;

  function automatic int dur_of(input int p);
    case (p)
      M_AG:        return int'(t_green_a);
      M_BG:        return int'(t_green_b);
      M_AY, M_BY:  return int'(t_yellow);
      M_WALK:      return int'(t_walk);
      default:     return int'(t_allred);
    endcase
  endfunction

  function automatic int follow(input int p);
    if (p == M_CLRB) return m_pend ? M_WALK : M_AG;
    if (p == M_WALK) return M_AG;
    return p + 1;
  endfunction

  function automatic logic [5:0] lamps(input int p, input bit f);
    case (p)
      M_AG:    return 6'b100001;
      M_AY:    return 6'b010001;
      M_BG:    return 6'b001100;
      M_BY:    return 6'b001010;
      M_FLASH: return f ? 6'b010010 : 6'b000000;
      default: return 6'b001001;
    endcase
  endfunction

  task automatic model_step();
    bit entry;
    int nx;
    entry = 0;
    if (!reset) begin
      m_ph = M_CLRB; m_rem = int'(t_allred) + 1; m_pend = 0; m_fph = 0; m_ack = 0;
    end else begin
      if (emerg) begin
        m_ph = M_EMRG; m_fph = 0;
      end else if (!enable) begin
        if (m_ph == M_FLASH) begin
          if (tick) m_fph = !m_fph;
        end else begin
          m_fph = 0;
        end
        m_ph = M_FLASH;
      end else if (m_ph == M_EMRG || m_ph == M_FLASH) begin
        m_ph = M_CLRB; m_rem = int'(t_allred) + 1; m_fph = 0;
      end else if (tick) begin
        m_rem--;
        if (m_rem == 0) begin
          nx    = follow(m_ph);
          entry = (nx == M_WALK);
          m_ph  = nx;
          m_rem = dur_of(nx) + 1;
        end
      end
      m_ack  = entry;
      m_pend = ped_req ? 1'b1 : (entry ? 1'b0 : m_pend);
    end
  endtask

  task automatic cyc(input bit r, input bit tk, input bit en, input bit em, input bit pr);
    @(negedge clk);
    reset = r; tick = tk; enable = en; emerg = em; ped_req = pr;
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    check("TL", 32'(TL), 32'(lamps(m_ph, m_fph)));
    check("walk", 32'(walk), 32'(m_ph == M_WALK));
    check("ped_ack", 32'(ped_ack), 32'(m_ack));
  endtask

  task automatic run_until(input int target, input int rem_target, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (m_ph == target && (rem_target < 0 || m_rem == rem_target)) ok = 1;
      else cyc(1, 1, 1, 0, 0);
    end
    if (!ok) check(tag, 32'(m_ph), 32'(target));
  endtask

  logic [5:0] seq1 [14] = '{6'b100001, 6'b100001, 6'b100001, 6'b100001, 6'b010001, 6'b010001,
                            6'b001001, 6'b001100, 6'b001100, 6'b001100, 6'b001100,
                            6'b001010, 6'b001010, 6'b001001};

  initial begin
    int acks, walks;
    bit em_r, en_r;
    t_green_a = 8'd3; t_green_b = 8'd3; t_yellow = 8'd1; t_allred = 8'd0; t_walk = 8'd2;

    // Reset, then one full normal cycle against the literal lamp sequence.
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("rst_TL", 32'(TL), 32'h09);
    check("rst_walk", 32'(walk), 32'h0);
    check("rst_ack", 32'(ped_ack), 32'h0);
    for (int i = 0; i < 14; i++) begin
      cyc(1, 1, 1, 0, 0);
      check("seq1", 32'(TL), 32'(seq1[i]));
    end

    // Pedestrian pulse during AG: one walk of t_walk+1 ticks, one ack, no repeat.
    acks = 0; walks = 0;
    cyc(1, 1, 1, 0, 1);
    for (int i = 0; i < 34; i++) begin
      cyc(1, 1, 1, 0, 0);
      acks += int'(ped_ack); walks += int'(walk);
    end
    check("ped_ack_cnt", 32'(acks), 32'd1);
    check("walk_cnt", 32'(walks), 32'd3);

    // Button held across WALK entry keeps the request pending.
    acks = 0; walks = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 1, 1, 0, 1);
      acks += int'(ped_ack); walks += int'(walk);
    end
    check("held_ack_cnt", 32'(acks), 32'd2);
    check("held_walk_cnt", 32'(walks), 32'd6);

    // Emergency mid-BG with two ticks left, then recovery through CLR_B.
    run_until(M_BG, 3, "reach_bg");
    for (int i = 0; i < 10; i++) cyc(1, i[0], 1, 1, 0);
    check("emrg_TL", 32'(TL), 32'h09);
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 0);

    // Flash mode entered from AY, tick on alternate cycles.
    run_until(M_AY, -1, "reach_ay");
    for (int i = 0; i < 12; i++) cyc(1, i[0], 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 0);

    // Reset mid-WALK with emergency asserted.
    cyc(1, 1, 1, 0, 1);
    run_until(M_WALK, -1, "reach_walk");
    cyc(0, 1, 1, 1, 0);
    check("rst6_TL", 32'(TL), 32'h09);
    check("rst6_walk", 32'(walk), 32'h0);
    walks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 1, 0, 0);
      walks += int'(walk);
    end
    check("rst6_no_walk", 32'(walks), 32'd0);

    // Random traffic with mid-phase duration edits.
    em_r = 0; en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) em_r = !em_r;
      if ($urandom_range(0, 49) == 0) en_r = !en_r;
      if ($urandom_range(0, 19) == 0) begin
        t_green_a = 8'($urandom_range(0, 4)); t_green_b = 8'($urandom_range(0, 4));
        t_yellow  = 8'($urandom_range(0, 3)); t_allred  = 8'($urandom_range(0, 2));
        t_walk    = 8'($urandom_range(0, 3));
      end
      cyc($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)), en_r, em_r,
          $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
